alu_result_lifo: RTL and testbench

- Stack buffer between the 3-bit ALU and the seven-segment LED driver.
- Each `execute` press pushes the ALU result and its opcode.
- Each `read` press pops the most recent entry into output holding registers, which the LED driver displays until the next pop.
- Button inputs are asynchronous and arrive as multi-cycle pulses, so the block synchronises and edge-detects them itself.

---
 rtl/alu_lifo_pkg.sv | 25 ++
 rtl/btn_sync_edge.sv | 48 ++++
 rtl/alu_result_lifo.sv | 172 +++++++++++++++++
 tb/tb_alu_result_lifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_lifo_pkg.sv
// ---------------------------------------------------------------------------
// alu_lifo_pkg
// Shared widths, the stack entry layout and the counter-width helper for the
// ALU result LIFO that sits between the 3-bit ALU and the LED driver.
// ---------------------------------------------------------------------------
package alu_lifo_pkg;

    localparam int DEPTH_DEF = 8;   // default number of stack entries
    localparam int RES_W_DEF = 6;   // default ALU result width
    localparam int OP_W_DEF  = 3;   // default opcode width

    // Counter must represent 0..DEPTH inclusive, hence one bit more than the index.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W = cnt_w(DEPTH_DEF);

    // One stack entry at the default widths: opcode in the upper bits.
    typedef struct packed {
        logic [OP_W_DEF-1:0]  opcode;
        logic [RES_W_DEF-1:0] result;
    } alu_entry_t;

endpackage : alu_lifo_pkg

// File: rtl/btn_sync_edge.sv
// ---------------------------------------------------------------------------
// btn_sync_edge
// Brings a raw, asynchronous push button into the clk domain and turns each
// press into a single-cycle strobe.
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high reset
//   btn_i   in   raw button level, asynchronous to clk
//   pulse_o out  one-cycle strobe, 2-3 clk after the raw rising edge
// ---------------------------------------------------------------------------
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       pulse_q;
    logic [1:0] fill_q;

    // NOTE: every flop here uses non-blocking assignment so the synchroniser
    // stages shift by exactly one flop per clock regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            // fill_q[1] goes high once sync2_q carries a real sample rather
            // than its reset value; until then prev_q is pinned at 1 so a
            // button held through reset release cannot look like a new edge.
            fill_q  <= {fill_q[0], 1'b1};
            prev_q  <= fill_q[1] ? sync2_q : 1'b1;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule : btn_sync_edge

// File: rtl/alu_result_lifo.sv
// ---------------------------------------------------------------------------
// alu_result_lifo
// Stack buffer between the ALU and the seven-segment LED driver. An
// `execute` press pushes {opcode_in, result_in}; a `read` press pops the most
// recent entry into holding registers shown until the next pop.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   execute, read         raw push / pop buttons (asynchronous)
//   result_in, opcode_in  entry to push, stable while execute is high
//   result_out/opcode_out last popped entry, held
//   out_valid             holding registers contain a popped entry
//   count                 entries stored (0..DEPTH)
//   empty, full           derived from count
//   overflow, underflow   sticky error flags, cleared only by reset
// ---------------------------------------------------------------------------
module alu_result_lifo
    import alu_lifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int RES_W = RES_W_DEF,
    parameter int OP_W  = OP_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   execute,
    input  logic                   read,
    input  logic [RES_W-1:0]       result_in,
    input  logic [OP_W-1:0]        opcode_in,
    output logic [RES_W-1:0]       result_out,
    output logic [OP_W-1:0]        opcode_out,
    output logic                   out_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = cnt_w(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [RES_W-1:0] result;
    } entry_t;

    logic push_s;
    logic pop_s;

    btn_sync_edge u_exec_sync (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (execute),
        .pulse_o (push_s)
    );

    btn_sync_edge u_read_sync (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (read),
        .pulse_o (pop_s)
    );

    entry_t            mem_q [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              is_empty;
    logic              is_full;
    logic [CW-1:0]     cnt_m1;
    logic [IDX_W-1:0]  top_idx;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    entry_t            wr_data;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign cnt_m1   = count_q - CW'(1);
    assign top_idx  = cnt_m1[IDX_W-1:0];
    assign wr_data  = '{opcode: opcode_in, result: result_in};

    // NOTE: every signal is given a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        res_d   = res_q;
        op_d    = op_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_idx  = count_q[IDX_W-1:0];

        unique case ({push_s, pop_s})
            2'b10: begin
                if (!is_full) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    res_d   = mem_q[top_idx].result;
                    op_d    = mem_q[top_idx].opcode;
                    valid_d = 1'b1;
                    count_d = cnt_m1;
                end else begin
                    udf_d = 1'b1;
                end
            end
            2'b11: begin
                if (!is_empty) begin
                    // Pop then push: the new entry replaces the old top in place.
                    res_d   = mem_q[top_idx].result;
                    op_d    = mem_q[top_idx].opcode;
                    valid_d = 1'b1;
                    wr_en   = 1'b1;
                    wr_idx  = top_idx;
                end else begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    count_d = CW'(1);
                    udf_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            res_q   <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            res_q   <= res_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // NOTE: the stack RAM has no reset; count_q alone decides which entries
    // are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign result_out = res_q;
    assign opcode_out = op_q;
    assign out_valid  = valid_q;
    assign count      = count_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule : alu_result_lifo

// File: tb/tb_alu_result_lifo.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_alu_result_lifo
// Directed, table-driven bench for alu_result_lifo (DEPTH=8, RES_W=6, OP_W=3)
// plus hand-written sequences for latency, held button, push+pop on empty
// and asynchronous reset with a button held.
// ---------------------------------------------------------------------------
module tb_alu_result_lifo;
    import alu_lifo_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             execute;
    logic             read;
    logic [5:0]       result_in;
    logic [2:0]       opcode_in;
    logic [5:0]       result_out;
    logic [2:0]       opcode_out;
    logic             out_valid;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_lifo #(.DEPTH(8), .RES_W(6), .OP_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .execute    (execute),
        .read       (read),
        .result_in  (result_in),
        .opcode_in  (opcode_in),
        .result_out (result_out),
        .opcode_out (opcode_out),
        .out_valid  (out_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    typedef enum logic [1:0] {ACT_PUSH, ACT_POP, ACT_BOTH} act_e;

    typedef struct {
        act_e act;
        int   op;
        int   res;
        int   e_res;
        int   e_op;
        int   e_valid;
        int   e_count;
        int   e_ovf;
        int   e_udf;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Press the requested button(s) for 5 clk, release, let the strobe settle.
    task automatic do_op(input act_e act, input int op, input int res);
        alu_entry_t e;
        e = '{opcode: 3'(op), result: 6'(res)};
        @(negedge clk);
        opcode_in = e.opcode;
        result_in = e.result;
        execute   = (act == ACT_PUSH) || (act == ACT_BOTH);
        read      = (act == ACT_POP)  || (act == ACT_BOTH);
        repeat (5) @(negedge clk);
        execute = 1'b0;
        read    = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;

        // act, op, res | e_res, e_op, e_valid, e_count, e_ovf, e_udf
        vecs[0]  = '{ACT_POP,  0,  0,  0, 0, 0, 0, 0, 1};
        vecs[1]  = '{ACT_PUSH, 0,  5,  0, 0, 0, 1, 0, 1};
        vecs[2]  = '{ACT_PUSH, 1, 12,  0, 0, 0, 2, 0, 1};
        vecs[3]  = '{ACT_PUSH, 2, 33,  0, 0, 0, 3, 0, 1};
        vecs[4]  = '{ACT_POP,  0,  0, 33, 2, 1, 2, 0, 1};
        vecs[5]  = '{ACT_POP,  0,  0, 12, 1, 1, 1, 0, 1};
        vecs[6]  = '{ACT_POP,  0,  0,  5, 0, 1, 0, 0, 1};
        vecs[7]  = '{ACT_PUSH, 3,  7,  5, 0, 1, 1, 0, 1};
        vecs[8]  = '{ACT_BOTH, 4,  9,  7, 3, 1, 1, 0, 1};
        vecs[9]  = '{ACT_POP,  0,  0,  9, 4, 1, 0, 0, 1};
        for (int k = 0; k < 8; k++)
            vecs[10+k] = '{ACT_PUSH, k, 20 + k, 9, 4, 1, k + 1, 0, 1};
        vecs[18] = '{ACT_BOTH, 6, 50, 27, 7, 1, 8, 0, 1};
        vecs[19] = '{ACT_PUSH, 7, 63, 27, 7, 1, 8, 1, 1};
        vecs[20] = '{ACT_POP,  0,  0, 50, 6, 1, 7, 1, 1};

        reset     = 1'b1;
        execute   = 1'b0;
        read      = 1'b0;
        result_in = '0;
        opcode_in = '0;
        do_reset();

        check("reset result_out", result_out, 0);
        check("reset opcode_out", opcode_out, 0);
        check("reset out_valid",  out_valid,  0);
        check("reset count",      count,      0);
        check("reset empty",      empty,      1);
        check("reset full",       full,       0);
        check("reset overflow",   overflow,   0);
        check("reset underflow",  underflow,  0);

        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].act, vecs[i].op, vecs[i].res);
            check($sformatf("row%0d result_out", i), result_out, vecs[i].e_res);
            check($sformatf("row%0d opcode_out", i), opcode_out, vecs[i].e_op);
            check($sformatf("row%0d out_valid",  i), out_valid,  vecs[i].e_valid);
            check($sformatf("row%0d count",      i), count,      vecs[i].e_count);
            check($sformatf("row%0d overflow",   i), overflow,   vecs[i].e_ovf);
            check($sformatf("row%0d underflow",  i), underflow,  vecs[i].e_udf);
            check($sformatf("row%0d empty",      i), empty,      (vecs[i].e_count == 0) ? 1 : 0);
            check($sformatf("row%0d full",       i), full,       (vecs[i].e_count == 8) ? 1 : 0);
        end

        // Strobe latency and held button: raw rise mid-cycle, count must move
        // on the 3rd or 4th rising edge, and 40 clk of holding gives one push.
        do_reset();
        @(negedge clk);
        opcode_in = 3'd2;
        result_in = 6'd44;
        execute   = 1'b1;
        n   = 0;
        got = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(posedge clk);
            #1;
            if (count == 1) begin
                got = 1'b1;
                n   = c;
            end
        end
        check($sformatf("push latency edges=%0d in 3..4", n), (got && n >= 3 && n <= 4) ? 1 : 0, 1);
        repeat (40) @(negedge clk);
        check("held execute count", count, 1);
        execute = 1'b0;
        repeat (5) @(negedge clk);
        check("released execute count", count, 1);
        do_op(ACT_POP, 0, 0);
        check("held push popped result", result_out, 44);
        check("held push popped opcode", opcode_out, 2);

        // Simultaneous push and pop on an empty stack.
        do_reset();
        do_op(ACT_BOTH, 1, 17);
        check("both-empty underflow",  underflow,  1);
        check("both-empty count",      count,      1);
        check("both-empty out_valid",  out_valid,  0);
        check("both-empty result_out", result_out, 0);
        do_op(ACT_POP, 0, 0);
        check("both-empty pop result", result_out, 17);
        check("both-empty pop opcode", opcode_out, 1);
        check("both-empty pop count",  count,      0);

        // Asynchronous reset mid-stack with read held through release.
        do_reset();
        for (int k = 0; k < 6; k++)
            do_op(ACT_PUSH, k, 30 + k);
        do_op(ACT_POP, 0, 0);
        check("pre-reset count",      count,      5);
        check("pre-reset result_out", result_out, 35);
        @(negedge clk);
        read = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async reset count",      count,      0);
        check("async reset result_out", result_out, 0);
        check("async reset opcode_out", opcode_out, 0);
        check("async reset out_valid",  out_valid,  0);
        check("async reset empty",      empty,      1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("held read underflow", underflow, 0);
        check("held read count",     count,     0);
        check("held read out_valid", out_valid, 0);
        read = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_result_lifo
